// File: rtl/vedic_pipe_mult.sv
// Three-stage pipelined Vedic (Urdhva-Tiryagbhyam) unsigned multiplier.
// Operands are split into halves. The four quadrant products are registered,
// then summed into the full-width product. In approximate mode the low
// APPROX_BITS of the lo*lo quadrant are cleared before the sum.
// All stages share one stall signal, so the pipeline moves as a unit.
module vedic_pipe_mult #(
    parameter int WIDTH       = 16,
    parameter int APPROX_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 out_mode
);

    localparam int H = WIDTH / 2;

    // Keeps the bits at or above APPROX_BITS. The value is all-ones when
    // APPROX_BITS is 0 and all-zeros when APPROX_BITS equals WIDTH.
    function automatic logic [WIDTH-1:0] approx_mask();
        logic [WIDTH-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            m[i] = (int'(i) >= APPROX_BITS);
        end
        return m;
    endfunction

    localparam logic [WIDTH-1:0] LL_MASK = approx_mask();

    // Handshake
    logic stall;

    // Stage 1: captured operands
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_mode;

    // Quadrant products computed from stage 1
    logic [WIDTH-1:0] q_hh;
    logic [WIDTH-1:0] q_hl;
    logic [WIDTH-1:0] q_lh;
    logic [WIDTH-1:0] q_ll;
    logic [WIDTH-1:0] q_ll_eff;

    // Stage 2: registered quadrant products
    logic             s2_valid;
    logic [WIDTH-1:0] s2_hh;
    logic [WIDTH-1:0] s2_hl;
    logic [WIDTH-1:0] s2_lh;
    logic [WIDTH-1:0] s2_ll;
    logic             s2_mode;

    // Final sum computed from stage 2
    logic [2*WIDTH-1:0] sum_hh;
    logic [2*WIDTH-1:0] sum_mid;
    logic [2*WIDTH-1:0] sum_ll;
    logic [2*WIDTH-1:0] sum;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Stage 1: capture operands and mode. A bubble is loaded when in_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_mode  <= 1'b0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a    <= a;
                s1_b    <= b;
                s1_mode <= mode;
            end
        end
    end

    // Vedic quadrant products. Each half is zero-extended to WIDTH bits so
    // that no carry is lost. Approximate mode clears the low bits of lo*lo.
    always_comb begin
        q_hh     = {{H{1'b0}}, s1_a[WIDTH-1:H]} * {{H{1'b0}}, s1_b[WIDTH-1:H]};
        q_hl     = {{H{1'b0}}, s1_a[WIDTH-1:H]} * {{H{1'b0}}, s1_b[H-1:0]};
        q_lh     = {{H{1'b0}}, s1_a[H-1:0]}     * {{H{1'b0}}, s1_b[WIDTH-1:H]};
        q_ll     = {{H{1'b0}}, s1_a[H-1:0]}     * {{H{1'b0}}, s1_b[H-1:0]};
        q_ll_eff = s1_mode ? (q_ll & LL_MASK) : q_ll;
    end

    // Stage 2: register the quadrant products together with the mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_hh    <= '0;
            s2_hl    <= '0;
            s2_lh    <= '0;
            s2_ll    <= '0;
            s2_mode  <= 1'b0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_hh   <= q_hh;
                s2_hl   <= q_hl;
                s2_lh   <= q_lh;
                s2_ll   <= q_ll_eff;
                s2_mode <= s1_mode;
            end
        end
    end

    // Recombine the quadrants: (hh << WIDTH) + ((hl + lh) << H) + ll.
    // The cross-term sum is widened before the add so its carry is kept.
    always_comb begin
        sum_hh  = {s2_hh, {WIDTH{1'b0}}};
        sum_mid = ({{WIDTH{1'b0}}, s2_hl} + {{WIDTH{1'b0}}, s2_lh}) << H;
        sum_ll  = {{WIDTH{1'b0}}, s2_ll};
        sum     = sum_hh + sum_mid + sum_ll;
    end

    // Stage 3: output register. The result is loaded only for valid data,
    // so out stays unchanged while bubbles pass through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_mode  <= 1'b0;
        end else if (!stall) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out      <= sum;
                out_mode <= s2_mode;
            end
        end
    end

endmodule
